// File: rtl/jelly_stream_width_convert_packed_if.sv
// Stream handshake bundle for the packed width converter: S_NUM-unit input
// beats on the s_* side, M_NUM-unit output beats on the m_* side.
interface jelly_stream_width_convert_packed_if #(
  parameter int UNIT_WIDTH = 8,
  parameter int S_NUM      = 3,
  parameter int M_NUM      = 4
);
  logic [S_NUM*UNIT_WIDTH-1:0] s_data;
  logic                        s_last;
  logic                        s_valid;
  logic                        s_ready;
  logic [M_NUM*UNIT_WIDTH-1:0] m_data;
  logic [M_NUM-1:0]            m_keep;
  logic                        m_last;
  logic                        m_valid;
  logic                        m_ready;

  // converter side
  modport slave (
    input  s_data, s_last, s_valid,
    output s_ready,
    output m_data, m_keep, m_last, m_valid,
    input  m_ready
  );

  // upstream/downstream side
  modport master (
    output s_data, s_last, s_valid,
    input  s_ready,
    input  m_data, m_keep, m_last, m_valid,
    output m_ready
  );
endinterface

// File: rtl/jelly_stream_width_convert_packed.sv
// Packed stream width converter. Input units are appended to a unit buffer in
// arrival order (unit0 = oldest, held at the LSB end of r_buf); output beats
// are read from the head. s_last arms a flush so the residue leaves as a
// padded final beat with m_keep marking the valid units.
module jelly_stream_width_convert_packed #(
  parameter int                    UNIT_WIDTH   = 8,
  parameter int                    S_NUM        = 3,
  parameter int                    M_NUM        = 4,
  parameter int                    BUF_NUM      = S_NUM + M_NUM,
  parameter int                    COUNT_WIDTH  = $clog2(BUF_NUM + 1),
  parameter logic [UNIT_WIDTH-1:0] PADDING_DATA = {UNIT_WIDTH{1'b0}}
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  endian,
  jelly_stream_width_convert_packed_if.slave    bus,
  output logic [COUNT_WIDTH-1:0]                buf_count
);

  localparam int                     BUF_W = BUF_NUM * UNIT_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] C_S   = COUNT_WIDTH'(S_NUM);
  localparam logic [COUNT_WIDTH-1:0] C_M   = COUNT_WIDTH'(M_NUM);
  localparam logic [COUNT_WIDTH-1:0] C_LIM = COUNT_WIDTH'(BUF_NUM - S_NUM);

  logic [BUF_W-1:0]              r_buf;
  logic [COUNT_WIDTH-1:0]        r_count;
  logic                          r_flush;
  logic                          r_run;

  logic                          w_s_ready;
  logic                          w_m_valid;
  logic                          w_m_last;
  logic                          w_accept;
  logic                          w_emit;
  logic [COUNT_WIDTH-1:0]        w_emit_num;
  logic [COUNT_WIDTH-1:0]        w_count_mid;
  logic [COUNT_WIDTH-1:0]        w_count_next;
  logic [S_NUM*UNIT_WIDTH-1:0]   w_s_flat;
  logic [BUF_W-1:0]              w_shifted;
  logic [BUF_W-1:0]              w_mask;
  logic [BUF_W-1:0]              w_buf_next;
  logic [M_NUM*UNIT_WIDTH-1:0]   w_m_data;
  logic [M_NUM-1:0]              w_m_keep;

  // Handshake flags depend only on registered state; m_ready never reaches s_ready.
  always_comb begin
    w_s_ready  = r_run && (r_count <= C_LIM) && !r_flush;
    w_m_valid  = (r_count >= C_M) || (r_flush && (r_count != '0));
    w_m_last   = r_flush && (r_count != '0) && (r_count <= C_M);
    w_accept   = bus.s_valid && w_s_ready;
    w_emit     = w_m_valid && bus.m_ready;
    w_emit_num = '0;
    if (w_emit) begin
      w_emit_num = (r_count >= C_M) ? C_M : r_count;
    end
  end

  // Normalise incoming units to arrival order, unit0 in the low slot.
  always_comb begin
    w_s_flat = '0;
    for (int k = 0; k < S_NUM; k++) begin
      if (endian) begin
        w_s_flat[k*UNIT_WIDTH +: UNIT_WIDTH] = bus.s_data[(S_NUM-1-k)*UNIT_WIDTH +: UNIT_WIDTH];
      end else begin
        w_s_flat[k*UNIT_WIDTH +: UNIT_WIDTH] = bus.s_data[k*UNIT_WIDTH +: UNIT_WIDTH];
      end
    end
  end

  // Drop emitted head units, then append the accepted beat right after the survivors.
  // Slots above the live count may hold stale units; the output padding hides them.
  always_comb begin
    w_count_mid  = r_count - w_emit_num;
    w_count_next = w_count_mid + (w_accept ? C_S : '0);
    w_shifted    = r_buf >> (int'(w_emit_num) * UNIT_WIDTH);
    w_mask       = ~({BUF_W{1'b1}} << (int'(w_count_mid) * UNIT_WIDTH));
    w_buf_next   = w_shifted;
    if (w_accept) begin
      w_buf_next = (w_shifted & w_mask) | (BUF_W'(w_s_flat) << (int'(w_count_mid) * UNIT_WIDTH));
    end
  end

  // Head units to the output; slots beyond the live count carry padding and keep=0.
  always_comb begin
    w_m_data = '0;
    w_m_keep = '0;
    if (r_count != '0) begin
      for (int i = 0; i < M_NUM; i++) begin
        w_m_keep[i] = (COUNT_WIDTH'(i) < r_count);
        if (endian) begin
          w_m_data[(M_NUM-1-i)*UNIT_WIDTH +: UNIT_WIDTH] = w_m_keep[i] ? r_buf[i*UNIT_WIDTH +: UNIT_WIDTH] : PADDING_DATA;
        end else begin
          w_m_data[i*UNIT_WIDTH +: UNIT_WIDTH]           = w_m_keep[i] ? r_buf[i*UNIT_WIDTH +: UNIT_WIDTH] : PADDING_DATA;
        end
      end
    end
  end

  // Buffer, occupancy and flush state; r_run holds s_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf   <= '0;
      r_count <= '0;
      r_flush <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_count <= w_count_next;
      if (w_accept || w_emit) begin
        r_buf <= w_buf_next;
      end
      if (w_emit && w_m_last) begin
        r_flush <= 1'b0;
      end else if (w_accept && bus.s_last) begin
        r_flush <= 1'b1;
      end
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = w_m_valid;
  assign bus.m_last  = w_m_last;
  assign bus.m_data  = w_m_data;
  assign bus.m_keep  = w_m_keep;
  assign buf_count   = r_count;

endmodule

// File: tb/tb_jelly_stream_width_convert_packed.sv
// Bench for the packed width converter: directed packets with literal
// expectations plus a long randomized run against a queue-based model.
module tb_jelly_stream_width_convert_packed;
  localparam int W   = 8;
  localparam int S   = 3;
  localparam int M   = 4;
  localparam int BUF = S + M;
  localparam int CW  = $clog2(BUF + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          endian = 1'b0;
  logic [CW-1:0] buf_count;

  jelly_stream_width_convert_packed_if #(.UNIT_WIDTH(W), .S_NUM(S), .M_NUM(M)) bus ();

  jelly_stream_width_convert_packed #(.UNIT_WIDTH(W), .S_NUM(S), .M_NUM(M)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .endian    (endian),
    .bus       (bus),
    .buf_count (buf_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model state
  int               pend[$];
  logic [M*W-1:0]   exp_data[$];
  logic [M-1:0]     exp_keep[$];
  logic             exp_last[$];
  int               occ = 0;
  bit               mflush = 0;
  bit               edge_seen;
  // observed beats, for literal checks
  logic [M*W-1:0]   log_data[$];
  logic [M-1:0]     log_keep[$];
  logic             log_last[$];
  // stall tracking
  bit               prev_stall = 0;
  logic [M*W-1:0]   prev_data;
  logic [M-1:0]     prev_keep;
  logic             prev_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [S*W-1:0] pack_s(input int base);
    logic [S*W-1:0] d;
    d = '0;
    for (int k = 0; k < S; k++) begin
      if (endian) d[(S-1-k)*W +: W] = W'((base + k) & 255);
      else        d[k*W +: W]       = W'((base + k) & 255);
    end
    return d;
  endfunction

  // turn n pending units into one expected output beat
  task automatic push_beat(input int n, input bit last);
    logic [M*W-1:0] d;
    logic [M-1:0]   kp;
    int             u;
    d  = '0;
    kp = '0;
    for (int i = 0; i < M; i++) begin
      u = 0;
      if (i < n) begin
        u = pend.pop_front();
        kp[i] = 1'b1;
      end
      if (endian) d[(M-1-i)*W +: W] = W'(u);
      else        d[i*W +: W]       = W'(u);
    end
    exp_data.push_back(d);
    exp_keep.push_back(kp);
    exp_last.push_back(last);
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_seen <= 1'b0;
    else          edge_seen <= 1'b1;
  end

  // single compare process: outputs are checked, then the accepted input is folded into the model
  always @(negedge clk) begin
    if (!reset_n) begin
      pend.delete(); exp_data.delete(); exp_keep.delete(); exp_last.delete();
      occ = 0; mflush = 0; prev_stall = 0;
    end else begin
      chk("buf_count", 64'(buf_count), 64'(occ));
      chk("s_ready", 64'(bus.s_ready), 64'(edge_seen && (occ <= BUF - S) && !mflush));
      chk("m_valid", 64'(bus.m_valid), 64'((occ >= M) || (mflush && occ > 0)));
      chk("buf_bound", 64'(buf_count <= CW'(BUF)), 64'(1));
      if (prev_stall) begin
        chk("stall_data", 64'(bus.m_data), 64'(prev_data));
        chk("stall_keep", 64'(bus.m_keep), 64'(prev_keep));
        chk("stall_last", 64'(bus.m_last), 64'(prev_last));
      end
      if (bus.m_valid && bus.m_ready) begin
        log_data.push_back(bus.m_data);
        log_keep.push_back(bus.m_keep);
        log_last.push_back(bus.m_last);
        checks++;
        if (exp_data.size() == 0) begin
          failures++;
          $display("FAIL extra_beat actual=%0h required=none @%0t", bus.m_data, $time);
        end else begin
          checks--;
          chk("beat_data", 64'(bus.m_data), 64'(exp_data[0]));
          chk("beat_keep", 64'(bus.m_keep), 64'(exp_keep[0]));
          chk("beat_last", 64'(bus.m_last), 64'(exp_last[0]));
          occ -= $countones(exp_keep[0]);
          if (exp_last[0]) mflush = 0;
          void'(exp_data.pop_front()); void'(exp_keep.pop_front()); void'(exp_last.pop_front());
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_keep  = bus.m_keep;
      prev_last  = bus.m_last;
      if (bus.s_valid && bus.s_ready) begin
        for (int k = 0; k < S; k++) begin
          if (endian) pend.push_back(int'(bus.s_data[(S-1-k)*W +: W]));
          else        pend.push_back(int'(bus.s_data[k*W +: W]));
        end
        occ += S;
        if (bus.s_last) begin
          mflush = 1;
          while (pend.size() > M) push_beat(M, 1'b0);
          push_beat(pend.size(), 1'b1);
        end else begin
          while (pend.size() >= M) push_beat(M, 1'b0);
        end
      end
    end
  end

  task automatic drive(input logic [S*W-1:0] d, input logic last);
    bit r;
    int n;
    n = 0;
    bus.s_data = d; bus.s_last = last; bus.s_valid = 1'b1;
    do begin
      @(negedge clk); r = bus.s_ready;
      @(posedge clk); #1; n++;
    end while (!r && n < 200);
    chk("drive_accept", 64'(r), 64'(1));
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_data.delete(); log_keep.delete(); log_last.delete();
  endtask

  initial begin
    int  unit_ctr;
    int  sent;
    int  cyc;
    bit  acc;
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    #3;
    chk("rst_m_valid", 64'(bus.m_valid), 64'(0));
    chk("rst_m_last",  64'(bus.m_last),  64'(0));
    chk("rst_m_keep",  64'(bus.m_keep),  64'(0));
    chk("rst_m_data",  64'(bus.m_data),  64'(0));
    chk("rst_count",   64'(buf_count),   64'(0));
    chk("rst_s_ready", 64'(bus.s_ready), 64'(0));
    idle(2);
    reset_n = 1'b1;
    idle(1);
    chk("s_ready_after_release", 64'(bus.s_ready), 64'(1));

    // basic packing
    clear_log(); bus.m_ready = 1'b1;
    drive(24'h020100, 1'b0);
    drive(24'h050403, 1'b0);
    chk("latency_m_valid", 64'(bus.m_valid), 64'(1));
    drive(24'h080706, 1'b0);
    drive(24'h0B0A09, 1'b0);
    idle(4);
    chk("basic_beats", 64'(log_data.size()), 64'(3));
    if (log_data.size() == 3) begin
      chk("basic_d0", 64'(log_data[0]), 64'h03020100);
      chk("basic_d1", 64'(log_data[1]), 64'h07060504);
      chk("basic_d2", 64'(log_data[2]), 64'h0B0A0908);
      chk("basic_k2", 64'(log_keep[2]), 64'hF);
      chk("basic_l2", 64'(log_last[2]), 64'h0);
    end
    chk("basic_count", 64'(buf_count), 64'(0));

    // flush with padding
    clear_log(); bus.m_ready = 1'b0;
    drive(24'h020100, 1'b0);
    drive(24'h050403, 1'b1);
    chk("flush_s_ready_low", 64'(bus.s_ready), 64'(0));
    bus.m_ready = 1'b1;
    idle(4);
    chk("flush_beats", 64'(log_data.size()), 64'(2));
    if (log_data.size() == 2) begin
      chk("flush_d0", 64'(log_data[0]), 64'h03020100);
      chk("flush_k0", 64'(log_keep[0]), 64'hF);
      chk("flush_l0", 64'(log_last[0]), 64'h0);
      chk("flush_d1", 64'(log_data[1]), 64'h00000504);
      chk("flush_k1", 64'(log_keep[1]), 64'h3);
      chk("flush_l1", 64'(log_last[1]), 64'h1);
    end
    chk("flush_s_ready_back", 64'(bus.s_ready), 64'(1));

    // exact fit
    clear_log();
    drive(24'h020100, 1'b0);
    drive(24'h050403, 1'b0);
    drive(24'h080706, 1'b0);
    drive(24'h0B0A09, 1'b1);
    idle(6);
    chk("exact_beats", 64'(log_data.size()), 64'(3));
    if (log_data.size() == 3) begin
      chk("exact_d2", 64'(log_data[2]), 64'h0B0A0908);
      chk("exact_k2", 64'(log_keep[2]), 64'hF);
      chk("exact_l2", 64'(log_last[2]), 64'h1);
    end

    // big-endian unit order
    clear_log(); endian = 1'b1;
    drive(24'h000102, 1'b0);
    drive(24'h030405, 1'b1);
    idle(4);
    chk("endian_beats", 64'(log_data.size()), 64'(2));
    if (log_data.size() == 2) begin
      chk("endian_d0", 64'(log_data[0]), 64'h00010203);
      chk("endian_d1", 64'(log_data[1]), 64'h04050000);
      chk("endian_k1", 64'(log_keep[1]), 64'h3);
    end
    endian = 1'b0;
    idle(1);

    // reset in the middle of a flushing packet
    bus.m_ready = 1'b0;
    drive(24'h020100, 1'b0);
    drive(24'h050403, 1'b1);
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    chk("mid_count_before", 64'(buf_count), 64'(2));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", 64'(bus.m_valid), 64'(0));
    chk("mid_rst_count",   64'(buf_count),   64'(0));
    @(negedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    idle(1);
    clear_log(); bus.m_ready = 1'b1;
    drive(24'h020100, 1'b0);
    drive(24'h050403, 1'b0);
    drive(24'h080706, 1'b1);
    idle(5);
    chk("mid_beats", 64'(log_data.size()), 64'(3));
    if (log_data.size() == 3) begin
      chk("mid_d0", 64'(log_data[0]), 64'h03020100);
      chk("mid_k0", 64'(log_keep[0]), 64'hF);
      chk("mid_d2", 64'(log_data[2]), 64'h00000008);
      chk("mid_k2", 64'(log_keep[2]), 64'h1);
    end

    // randomized traffic with backpressure
    unit_ctr = 0; sent = 0; cyc = 0;
    while (sent < 10000 && cyc < 60000) begin
      if (!bus.s_valid && ($urandom_range(3) != 0)) begin
        bus.s_valid = 1'b1;
        bus.s_data  = pack_s(unit_ctr);
        bus.s_last  = ($urandom_range(15) == 0);
      end
      bus.m_ready = ($urandom_range(9) < 7);
      @(negedge clk); acc = bus.s_valid && bus.s_ready;
      @(posedge clk); #1; cyc++;
      if (acc) begin
        unit_ctr += S; sent++;
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
      end
    end
    chk("random_sent", 64'(sent), 64'(10000));
    bus.m_ready = 1'b1;
    drive(pack_s(unit_ctr), 1'b1);
    cyc = 0;
    while ((buf_count != '0 || bus.m_valid) && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    idle(2);
    chk("drain_count", 64'(buf_count), 64'(0));
    chk("drain_exp_empty", 64'(exp_data.size()), 64'(0));
    chk("drain_pend_empty", 64'(pend.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
